// File: rtl/riscv_fetch_fifo.sv
// Instruction fetch front end: issues word-aligned fetches to memory under a credit
// scheme and buffers returned {rdata, addr} pairs in a small FIFO for the decoder.
module riscv_fetch_fifo #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic          run_q;
    logic [31:0]   fetch_addr_q;
    logic          pending_q;
    logic          pend_stale_q;
    logic [31:0]   pend_addr_q;
    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] discard_q;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Addresses of granted transactions, oldest first, so each response is tagged correctly.
    logic [31:0]   txn_addr [MAX_OUTSTANDING];
    logic [QW-1:0] txn_wr_q;
    logic [QW-1:0] txn_rd_q;

    logic          new_req;
    logic          grant;
    logic          rvalid_ok;
    logic          stale_grant;
    logic          drop;
    logic          push;
    logic          pop;
    logic [OW-1:0] outstanding_d;
    logic [OW-1:0] discard_d;

    function automatic logic [QW-1:0] txn_next(input logic [QW-1:0] ptr);
        return (ptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Credit: FIFO entries plus responses still owed must never exceed DEPTH.
    assign new_req = run_q & req_i & ~branch_i & ~pending_q
                   & (outstanding_q < OW'(MAX_OUTSTANDING))
                   & ((32'(count_q) + 32'(outstanding_q)) < 32'(DEPTH));

    assign instr_req_o  = pending_q | new_req;
    assign instr_addr_o = pending_q ? pend_addr_q : fetch_addr_q;
    assign grant        = instr_req_o & instr_gnt_i;

    // A response with nothing in flight is stray (e.g. left over from before reset).
    assign rvalid_ok   = instr_rvalid_i & (outstanding_q != '0);
    assign stale_grant = grant & pending_q & pend_stale_q;
    assign drop        = rvalid_ok & (branch_i | (discard_q != '0));
    assign push        = rvalid_ok & ~drop;
    assign pop         = valid_o & ready_i;

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? fifo_data[rd_ptr_q] : '0;
    assign addr_o  = valid_o ? fifo_addr[rd_ptr_q] : '0;
    assign busy_o  = instr_req_o | (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (grant && !rvalid_ok) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!grant && rvalid_ok) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // On a redirect every transaction still unreturned after this edge becomes junk.
    always_comb begin
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = outstanding_d;
        end else if (stale_grant && !(rvalid_ok && discard_q != '0)) begin
            discard_d = discard_q + 1'b1;
        end else if (!stale_grant && rvalid_ok && discard_q != '0) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_addr_q  <= '0;
            pending_q     <= 1'b0;
            pend_stale_q  <= 1'b0;
            pend_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            txn_wr_q      <= '0;
            txn_rd_q      <= '0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;

            // An ungranted request is frozen; a redirect only marks it as junk.
            if (grant) begin
                pending_q    <= 1'b0;
                pend_stale_q <= 1'b0;
            end else if (instr_req_o) begin
                pending_q   <= 1'b1;
                pend_addr_q <= instr_addr_o;
                if (branch_i) begin
                    pend_stale_q <= 1'b1;
                end
            end

            if (branch_i) begin
                fetch_addr_q <= addr_i & 32'hFFFF_FFFC;
            end else if (grant && !pend_stale_q) begin
                fetch_addr_q <= instr_addr_o + 32'd4;
            end

            if (grant) begin
                txn_wr_q <= txn_next(txn_wr_q);
            end
            if (rvalid_ok) begin
                txn_rd_q <= txn_next(txn_rd_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (branch_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            txn_addr[txn_wr_q] <= instr_addr_o;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= instr_rdata_i;
            fifo_addr[wr_ptr_q] <= txn_addr[txn_rd_q];
        end
    end

endmodule

// File: tb/tb_riscv_fetch_fifo.sv
// Bench for riscv_fetch_fifo: directed scenarios followed by random traffic, checked
// against a memory model and the expected stream of fetched words.
module tb_riscv_fetch_fifo;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    riscv_fetch_fifo #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          n_pops;
    int          grants;
    bit          last_grant;
    bit          hold_req;
    bit          stale;
    bit          seen;
    logic [31:0] hold_addr;
    logic [31:0] model_fetch;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs after the rising edge, sample before the next one.
    task automatic run_cycle(input bit req, input bit br, input logic [31:0] baddr,
                             input bit rdy, input bit gnt, input bit rsp);
        logic [31:0] a;
        @(posedge clk); #1;
        req_i          = req;
        branch_i       = br;
        addr_i         = baddr;
        ready_i        = rdy;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rsp && (mem_q.size() != 0);
        instr_rdata_i  = instr_rvalid_i ? mem_word(mem_q[0]) : $urandom;
        @(negedge clk);
        if (hold_req) begin
            chk("req_held", instr_req_o, 1);
            chk("addr_held", instr_addr_o, hold_addr);
        end else if (instr_req_o) begin
            chk("fetch_addr", instr_addr_o, model_fetch);
        end
        chk("busy", busy_o, (instr_req_o || mem_q.size() != 0));
        if (valid_o && rdy) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", valid_o, 0);
            end else begin
                a = exp_q.pop_front();
                chk("pop_addr", addr_o, a);
                chk("pop_data", rdata_o, mem_word(a));
            end
        end
        if (instr_rvalid_i) void'(mem_q.pop_front());
        last_grant = instr_req_o && gnt;
        if (last_grant) begin
            mem_q.push_back(instr_addr_o);
            if (!stale) begin
                exp_q.push_back(instr_addr_o);
                model_fetch = instr_addr_o + 32'd4;
            end
            stale = 0;
            chk("outstanding_limit", (mem_q.size() <= MAX_OUT), 1);
        end
        hold_req  = instr_req_o && !gnt;
        hold_addr = instr_addr_o;
        if (br) begin
            exp_q.delete();
            model_fetch = baddr & 32'hFFFF_FFFC;
            if (hold_req) stale = 1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12; i++) run_cycle(0, 0, 0, 1, 1, 1);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic first_valid(input string tag, input logic [31:0] a);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (valid_o) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_addr"}, addr_o, a);
        chk({tag, "_data"}, rdata_o, mem_word(a));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 0;
        req_i = 1;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_req", instr_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", addr_o, 0);
        mem_q.delete();
        exp_q.delete();
        hold_req    = 0;
        stale       = 0;
        model_fetch = 32'h0;
        @(posedge clk); #1;
        req_i = 0; branch_i = 0; ready_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
        rst_n = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_pops = 0;
        rst_n = 0; req_i = 1; branch_i = 0; addr_i = 0; ready_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
        hold_req = 0; stale = 0; model_fetch = 0; hold_addr = 0;
        apply_reset();

        // Branch to 0x100 with immediate grant and single-cycle memory latency
        run_cycle(1, 1, 32'h100, 1, 1, 1);
        chk("t1_no_req_in_branch_cycle", instr_req_o, 0);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t1_req", instr_req_o, 1);
        chk("t1_req_addr", instr_addr_o, 32'h100);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t1_no_bypass", valid_o, 0);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t1_valid0", valid_o, 1);
        chk("t1_addr0", addr_o, 32'h100);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t1_addr1", addr_o, 32'h104);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t1_addr2", addr_o, 32'h108);
        drain("t1_drain");

        // Consumer stalled: credit must stop at exactly DEPTH grants
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1, 0, 0, 0, 1, 1);
            if (last_grant) grants++;
        end
        chk("t2_grants", grants, DEPTH);
        chk("t2_req_stopped", instr_req_o, 0);
        chk("t2_full_valid", valid_o, 1);
        chk("t2_model_occ", exp_q.size(), DEPTH);
        for (int i = 0; i < 8; i++) run_cycle(1, 0, 0, 1, 1, 1);
        drain("t2_drain");

        // Two transactions in flight when redirected to 0x200
        run_cycle(1, 0, 0, 1, 1, 0);
        run_cycle(1, 0, 0, 1, 1, 0);
        chk("t3_two_in_flight", busy_o, 1);
        run_cycle(1, 1, 32'h200, 1, 0, 1);
        first_valid("t3_first", 32'h200);
        drain("t3_drain");

        // Request to 0x40 stalled by memory while redirected to 0x80
        run_cycle(0, 1, 32'h40, 1, 0, 0);
        run_cycle(1, 0, 0, 1, 0, 0);
        chk("t4_req_addr", instr_addr_o, 32'h40);
        run_cycle(1, 1, 32'h80, 1, 0, 0);
        chk("t4_hold_on_branch", instr_addr_o, 32'h40);
        run_cycle(1, 0, 0, 1, 0, 0);
        chk("t4_hold_after_branch", instr_addr_o, 32'h40);
        run_cycle(1, 0, 0, 1, 1, 0);
        chk("t4_grant_addr", instr_addr_o, 32'h40);
        run_cycle(1, 0, 0, 0, 1, 1);
        chk("t4_next_req", instr_req_o, 1);
        chk("t4_next_addr", instr_addr_o, 32'h80);
        first_valid("t4_first", 32'h80);
        drain("t4_drain");

        // Address wrap at the top of memory; misaligned target is word-aligned
        run_cycle(0, 1, 32'hFFFF_FFFE, 1, 0, 0);
        run_cycle(1, 0, 0, 1, 1, 0);
        chk("t5_top_addr", instr_addr_o, 32'hFFFF_FFFC);
        run_cycle(1, 0, 0, 1, 1, 1);
        chk("t5_wrap_addr", instr_addr_o, 32'h0);
        drain("t5_drain");

        // Reset in the middle of outstanding transactions, then a stray response
        run_cycle(1, 0, 0, 1, 1, 0);
        run_cycle(1, 0, 0, 1, 1, 0);
        apply_reset();
        @(posedge clk); #1;
        instr_rvalid_i = 1;
        instr_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_no_req_after_reset", instr_req_o, 0);
        chk("t6_idle_busy", busy_o, 0);
        @(posedge clk); #1;
        instr_rvalid_i = 0;
        @(negedge clk);
        chk("t6_stray_dropped", valid_o, 0);

        // Random traffic
        n_pops = 0;
        for (int i = 0; i < 1500; i++) begin
            run_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom,
                      $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 9) < 5);
        end
        drain("rand_drain");
        chk("rand_progress", (n_pops > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_fifo.md
RISCV_FETCH_FIFO -- requirements
Module: riscv_fetch_fifo

Interface
REQ-001 Parameter DEPTH, default 4, gives the number of FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2, gives the maximum number of granted transactions without rvalid; it SHALL be at least 1.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low. Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_i  in  1  fetch enable
- branch_i  in  1  redirect fetch to addr_i
- addr_i  in  32  branch target
- ready_i  in  1  consumer pops head
- valid_o  out  1  head entry valid
- rdata_o  out  32  head instruction word
- addr_o  out  32  head word address
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  memory word address
- instr_gnt_i  in  1  request granted
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- busy_o  out  1  transaction pending or in flight

Function
REQ-004 State SHALL be:
- fetch_addr_q, word-aligned;
- pending_q, meaning a request is asserted and not yet granted, plus pend_addr_q;
- outstanding counter, meaning granted transactions without rvalid;
- discard counter;
- FIFO storage of {rdata, addr} with an occupancy count.
REQ-005 new_req SHALL be asserted when all of the following hold:
- req_i is high, branch_i is low and pending_q is low;
- outstanding < MAX_OUTSTANDING;
- occupancy + outstanding < DEPTH.
REQ-006 instr_req_o SHALL equal pending_q | new_req; instr_addr_o SHALL equal pending_q ? pend_addr_q : fetch_addr_q.
REQ-007 When instr_req_o is high and instr_gnt_i is low, pending_q SHALL be set and pend_addr_q SHALL hold the address. Request and address SHALL stay stable until grant, regardless of req_i or branch_i.
REQ-008 A grant (instr_req_o & instr_gnt_i) SHALL:
- increment outstanding;
- clear pending_q;
- set fetch_addr_q to the granted address + 4, unless a branch overrides it.
REQ-009 An instr_rvalid_i SHALL decrement outstanding. A grant and an rvalid in the same cycle SHALL leave outstanding unchanged.
REQ-010 An rvalid with discard = 0 SHALL write {instr_rdata_i, the address of that transaction} to the FIFO tail. Addresses SHALL be tracked in issue order.
REQ-011 An rvalid with discard > 0 SHALL drop the data and decrement discard.
REQ-012 valid_o SHALL equal (occupancy != 0). rdata_o and addr_o SHALL reflect the head entry.
REQ-013 Data SHALL be registered with no bypass: a write on rvalid in cycle N SHALL make valid_o high in cycle N+1.
REQ-014 valid_o & ready_i SHALL pop the head. A push and a pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-015 The FIFO SHALL never overflow; REQ-005 credit guarantees this. A pop with valid_o low SHALL be ignored.
REQ-016 On branch_i, at the next edge:
- the FIFO SHALL be flushed (occupancy = 0);
- fetch_addr_q SHALL be set to {addr_i[31:2], 2'b00};
- discard SHALL be set to (outstanding + grant_this_cycle - rvalid_this_cycle + existing discard adjustments), i.e. every transaction not yet returned at that edge;
- an rvalid in the branch cycle SHALL be dropped.
REQ-017 When branch_i occurs while pending_q is set, the old request SHALL complete per REQ-007, be counted into discard at its grant, and SHALL NOT advance fetch_addr_q.
REQ-018 The first request to the branch target SHALL assert no earlier than the cycle after branch_i.
REQ-019 busy_o SHALL equal instr_req_o | (outstanding != 0).
REQ-020 With req_i low, no new request SHALL start; pending and outstanding transactions SHALL complete normally.
REQ-021 Wrap-around: fetch_addr_q + 4 SHALL wrap modulo 2^32.

Reset
REQ-022 While rst_n is low, the following SHALL be 0: valid_o, instr_req_o, busy_o, fetch_addr_q, pending_q, outstanding, discard and occupancy. rdata_o and addr_o SHALL read 0.
REQ-023 Reset asserted mid-transaction SHALL abandon all state. After release, no request SHALL issue until branch_i or req_i is asserted.

Verification
REQ-024 Branch 0x100 in cycle 0, req_i=1, gnt immediate, rvalid one cycle after gnt -> instr_req_o=1 with addr 0x100 in cycle 1, valid_o=1 with addr_o=0x100 in cycle 3, then 0x104 and 0x108 in consecutive cycles.
REQ-025 ready_i=0, DEPTH=4 -> exactly 4 grants, instr_req_o stays low afterwards, occupancy 4. Then ready_i=1 with simultaneous rvalid -> no overflow and order preserved.
REQ-026 Two granted transactions in flight, then branch_i to 0x200 -> both responses dropped, first valid_o shows addr_o=0x200 and rdata equals the third response.
REQ-027 Request to 0x40 held with gnt=0 while branch_i to 0x80 -> instr_addr_o stays 0x40 until gnt; its response is discarded; the next request is 0x80.
REQ-028 fetch_addr_q=0xFFFFFFFC, grant -> next instr_addr_o=0x00000000.
REQ-029 rst_n low during an outstanding transaction -> all outputs 0 immediately; a stray rvalid after release produces no FIFO write.
